// File: rtl/alu_share_arbiter_if.sv
// Bundles the request/response handshakes of both requesters and the link
// to the shared ALU.
//   slave  : the arbiter's view (takes requests, drives grants, responses
//            and the ALU inputs)
//   master : the requesters' and ALU's view
// Signals:
//   req0/1, op0/1, a0/1, b0/1        request valid, operation and operands
//   gnt0/1                           combinational accept strobe
//   rsp_valid0/1, rsp_data0/1,
//   rsp_err0/1, rsp_ready0/1         response valid/ready handshake
//   alu_in1, alu_in2, alu_sel        operands and select to the shared ALU
//   alu_result                       result from the shared ALU
//   busy                             controller owns an operation
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req0;
    logic              req1;
    logic [OP_W-1:0]   op0;
    logic [OP_W-1:0]   op1;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
    logic              gnt0;
    logic              gnt1;
    logic              rsp_valid0;
    logic              rsp_valid1;
    logic [DATA_W-1:0] rsp_data0;
    logic [DATA_W-1:0] rsp_data1;
    logic              rsp_err0;
    logic              rsp_err1;
    logic              rsp_ready0;
    logic              rsp_ready1;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [OP_W-1:0]   alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic              busy;

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1,
        input  rsp_ready0, rsp_ready1, alu_result,
        output gnt0, gnt1,
        output rsp_valid0, rsp_valid1, rsp_data0, rsp_data1, rsp_err0, rsp_err1,
        output alu_in1, alu_in2, alu_sel, busy
    );

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1,
        output rsp_ready0, rsp_ready1, alu_result,
        input  gnt0, gnt1,
        input  rsp_valid0, rsp_valid1, rsp_data0, rsp_data1, rsp_err0, rsp_err1,
        input  alu_in1, alu_in2, alu_sel, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration.
// A request is accepted (gnt) when the controller is idle or its pending
// response is being consumed in the same cycle. Operands are latched at
// the accept edge, presented to the ALU for one EXEC cycle, and the result
// is held in RESP until the owning requester takes it.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      alu_share_arbiter_if.slave (requests, responses, ALU link)
//
// state | meaning
// IDLE  | no operation owned; any request is accepted
// EXEC  | latched operands drive the ALU; result captured at end of cycle
// RESP  | result presented to owner until rsp_valid & rsp_ready
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input logic             clk,
    input logic             reset_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              legal_q, legal_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;

    logic              rsp_fire;
    logic              win;
    logic              accept;
    logic              in_resp;
    logic [OP_W-1:0]   win_op;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        if (op == OP_W'(4'b0000) || op == OP_W'(4'b0001) || op == OP_W'(4'b0010) ||
            op == OP_W'(4'b0110) || op == OP_W'(4'b0111))
            ok = 1'b1;
        return ok;
    endfunction

    assign in_resp  = (state_q == ST_RESP);
    assign rsp_fire = in_resp & (owner_q ? bus.rsp_ready1 : bus.rsp_ready0);
    // Pointer only matters on contention; a lone requester always wins.
    assign win      = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
    assign win_op   = win ? bus.op1 : bus.op0;
    // reset_n gates the grant so no handshake completes while held in reset.
    assign accept   = ((state_q == ST_IDLE) | rsp_fire) & (bus.req0 | bus.req1) & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            legal_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            legal_q <= legal_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        legal_d = legal_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_RESP;
                rdata_d = legal_q ? bus.alu_result : '0;
                rerr_d  = ~legal_q;
            end
            ST_RESP: if (rsp_fire) state_d = accept ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            ptr_d   = ~win;
            owner_d = win;
            op_d    = win_op;
            a_d     = win ? bus.a1 : bus.a0;
            b_d     = win ? bus.b1 : bus.b0;
            legal_d = op_is_legal(win_op);
        end
    end

    assign bus.gnt0       = accept & ~win;
    assign bus.gnt1       = accept & win;
    assign bus.rsp_valid0 = in_resp & ~owner_q;
    assign bus.rsp_valid1 = in_resp & owner_q;
    // Non-owner response lines are forced to zero rather than mirroring the
    // shared result register.
    assign bus.rsp_data0  = (in_resp & ~owner_q) ? rdata_q : '0;
    assign bus.rsp_data1  = (in_resp & owner_q)  ? rdata_q : '0;
    assign bus.rsp_err0   = in_resp & ~owner_q & rerr_q;
    assign bus.rsp_err1   = in_resp & owner_q & rerr_q;
    assign bus.alu_in1    = a_q;
    assign bus.alu_in2    = b_q;
    assign bus.alu_sel    = op_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    alu_share_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus();

    alu_share_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU; illegal selects return junk that must never reach a requester.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit op_legal(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) || (op == 4'd7);
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_sel, bus.alu_in1, bus.alu_in2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Observed grants and consumed responses, for literal checks.
    int          g_id[$];
    int          g_cyc[$];
    int          r_id[$];
    int          r_cyc[$];
    logic [31:0] r_data[$];
    logic        r_err[$];

    // Transaction-level model: one in-flight op, aged in cycles since accept.
    bit          m_inflight;
    int          m_age;
    bit          m_owner;
    bit          m_ptr;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_data;
    bit          m_err;

    bit          e_can, e_fire, e_win, e_acc, e_v0, e_v1;
    logic [1:0]  rdy;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_inflight = 0;
            m_age      = 0;
            m_ptr      = 0;
            chk("rst_gnt0", bus.gnt0, 0);
            chk("rst_gnt1", bus.gnt1, 0);
            chk("rst_v0", bus.rsp_valid0, 0);
            chk("rst_v1", bus.rsp_valid1, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_in1", bus.alu_in1, 0);
            chk("rst_sel", bus.alu_sel, 0);
        end else begin
            rdy    = {bus.rsp_ready1, bus.rsp_ready0};
            e_fire = m_inflight && m_age >= 2 && rdy[m_owner];
            e_can  = !m_inflight || e_fire;
            e_win  = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
            e_acc  = e_can && (bus.req0 || bus.req1);
            e_v0   = m_inflight && m_age >= 2 && !m_owner;
            e_v1   = m_inflight && m_age >= 2 && m_owner;

            chk("gnt0", bus.gnt0, e_acc && !e_win);
            chk("gnt1", bus.gnt1, e_acc && e_win);
            chk("busy", bus.busy, m_inflight);
            chk("rsp_valid0", bus.rsp_valid0, e_v0);
            chk("rsp_valid1", bus.rsp_valid1, e_v1);
            chk("rsp_data0", bus.rsp_data0, e_v0 ? m_data : 32'd0);
            chk("rsp_data1", bus.rsp_data1, e_v1 ? m_data : 32'd0);
            chk("rsp_err0", bus.rsp_err0, e_v0 && m_err);
            chk("rsp_err1", bus.rsp_err1, e_v1 && m_err);
            if (m_inflight && m_age == 1) begin
                chk("alu_sel", bus.alu_sel, m_op);
                chk("alu_in1", bus.alu_in1, m_a);
                chk("alu_in2", bus.alu_in2, m_b);
            end

            if (bus.gnt0) begin g_id.push_back(0); g_cyc.push_back(cyc); end
            if (bus.gnt1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
            if (bus.rsp_valid0 && bus.rsp_ready0) begin
                r_id.push_back(0); r_cyc.push_back(cyc);
                r_data.push_back(bus.rsp_data0); r_err.push_back(bus.rsp_err0);
            end
            if (bus.rsp_valid1 && bus.rsp_ready1) begin
                r_id.push_back(1); r_cyc.push_back(cyc);
                r_data.push_back(bus.rsp_data1); r_err.push_back(bus.rsp_err1);
            end

            if (m_inflight) m_age++;
            if (e_fire) m_inflight = 0;
            if (e_acc) begin
                m_inflight = 1;
                m_age      = 1;
                m_owner    = e_win;
                m_op       = e_win ? bus.op1 : bus.op0;
                m_a        = e_win ? bus.a1 : bus.a0;
                m_b        = e_win ? bus.b1 : bus.b0;
                m_err      = !op_legal(m_op);
                m_data     = m_err ? 32'd0 : alu_fn(m_op, m_a, m_b);
                m_ptr      = !e_win;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grants(input int target, input int budget);
        for (int i = 0; i < budget && g_id.size() < target; i++) step(1);
        chk("grant_wait", g_id.size(), target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        bus.op0 = 0; bus.op1 = 0;
        bus.a0 = 0; bus.a1 = 0; bus.b0 = 0; bus.b1 = 0;
        bus.rsp_ready0 = 1; bus.rsp_ready1 = 1;
        #22;
        chk("init_busy", bus.busy, 0);
        chk("init_in2", bus.alu_in2, 0);
        #1 reset_n = 1;

        // Single ADD 5+7 from requester 0
        step(1);
        bus.req0 = 1; bus.op0 = 4'b0010; bus.a0 = 5; bus.b0 = 7;
        wait_grants(1, 10);
        bus.req0 = 0;
        step(4);
        chk("t1_gid", g_id[0], 0);
        chk("t1_nresp", r_id.size(), 1);
        chk("t1_data", r_data[0], 32'd12);
        chk("t1_err", r_err[0], 0);
        chk("t1_lat", r_cyc[0] - g_cyc[0], 2);
        chk("t1_idle", bus.busy, 0);

        // Illegal op from requester 1; grant also moves pointer back to 0
        bus.req1 = 1; bus.op1 = 4'b0011; bus.a1 = 32'h1234; bus.b1 = 32'h5678;
        wait_grants(2, 10);
        bus.req1 = 0;
        step(4);
        chk("t3_id", r_id[1], 1);
        chk("t3_data", r_data[1], 32'd0);
        chk("t3_err", r_err[1], 1);

        // Contention: both held, alternate grants every 2 cycles
        bus.req0 = 1; bus.op0 = 4'b0110; bus.a0 = 10; bus.b0 = 3;
        bus.req1 = 1; bus.op1 = 4'b0000; bus.a1 = 32'hF0F0_F0F0; bus.b1 = 32'h0FF0_0FF0;
        wait_grants(6, 20);
        bus.req0 = 0; bus.req1 = 0;
        step(4);
        chk("t2_g0", g_id[2], 0);
        chk("t2_g1", g_id[3], 1);
        chk("t2_g2", g_id[4], 0);
        chk("t2_g3", g_id[5], 1);
        chk("t2_sp1", g_cyc[3] - g_cyc[2], 2);
        chk("t2_sp2", g_cyc[4] - g_cyc[3], 2);
        chk("t2_sp3", g_cyc[5] - g_cyc[4], 2);
        chk("t2_d0", r_data[2], 32'd7);
        chk("t2_d1", r_data[3], 32'h00F0_00F0);
        chk("t2_d2", r_data[4], 32'd7);
        chk("t2_d3", r_data[5], 32'h00F0_00F0);

        // SLT 3<9 with stalled consumer; req1 waits for the fire cycle
        bus.rsp_ready0 = 0;
        bus.req0 = 1; bus.op0 = 4'b0111; bus.a0 = 3; bus.b0 = 9;
        wait_grants(7, 10);
        bus.req0 = 0;
        bus.req1 = 1; bus.op1 = 4'b0001; bus.a1 = 32'h30; bus.b1 = 32'h03;
        step(1);
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_v", bus.rsp_valid0, 1);
            chk("t4_hold_d", bus.rsp_data0, 32'd1);
            chk("t4_no_gnt1", bus.gnt1, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready0 = 1;
        @(negedge clk);
        chk("t4_gnt1", bus.gnt1, 1);
        chk("t4_fire_v", bus.rsp_valid0, 1);
        @(posedge clk); #1;
        bus.req1 = 0;
        step(4);
        chk("t4_rid", r_id[6], 0);
        chk("t4_same", g_cyc[7], r_cyc[6]);
        chk("t4_or", r_data[7], 32'h33);

        // Reset in the middle of EXEC drops the op
        bus.req0 = 1; bus.op0 = 4'b0010; bus.a0 = 1; bus.b0 = 1;
        wait_grants(9, 10);
        bus.req0 = 0;
        chk("t5_exec", bus.busy, 1);
        #2 reset_n = 0;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_in1", bus.alu_in1, 0);
        chk("t5_in2", bus.alu_in2, 0);
        chk("t5_sel", bus.alu_sel, 0);
        chk("t5_v0", bus.rsp_valid0, 0);
        @(posedge clk);
        #3 reset_n = 1;
        step(4);
        chk("t5_noresp", r_id.size(), 8);
        bus.req0 = 1; bus.op0 = 4'b0001; bus.a0 = 32'hA; bus.b0 = 32'h5;
        wait_grants(10, 10);
        bus.req0 = 0;
        step(4);
        chk("t5_id", r_id[8], 0);
        chk("t5_or", r_data[8], 32'hF);

        // req0 withdrawn while requester 1's response is stalled
        bus.rsp_ready1 = 0;
        bus.req1 = 1; bus.op1 = 4'b0010; bus.a1 = 100; bus.b1 = 23;
        wait_grants(11, 10);
        bus.req1 = 0;
        step(1);
        bus.req0 = 1; bus.op0 = 4'b0000; bus.a0 = 32'hFF; bus.b0 = 32'h0F;
        step(2);
        bus.req0 = 0;
        step(1);
        bus.rsp_ready1 = 1;
        step(4);
        chk("t6_ngnt", g_id.size(), 11);
        chk("t6_nresp", r_id.size(), 10);
        chk("t6_id", r_id[9], 1);
        chk("t6_data", r_data[9], 32'd123);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
